uart_tx: RTL and testbench

- Serial transmitter for the CPU's debug/console link. It is the sending end of the asynchronous serial line whose receive side is built from D flip-flop capture and shift stages.
- Accepts one parallel word per valid/ready handshake and emits it on a single line as an 8N1-style frame: start bit low, data bits LSB first, stop bit high.
- Sits between the CPU's I/O register logic and the board TX pin.

---
 rtl/uart_tx.sv | 113 +++++++++++
 tb/tb_uart_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial transmitter: one word per valid/ready handshake, sent as start bit,
// DATA_BITS data bits LSB first, and a stop bit, each CLKS_PER_BIT clocks long.
module uart_tx #(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS) + 1;

   localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] shift_nxt;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      shift_nxt = shift_q >> 1;
      bit_end   = (baud_q == LAST_BAUD);
      baud_d    = bit_end ? '0 : baud_q + BAUD_W'(1);

      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (tx_valid) begin
               shift_d = tx_data;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == LAST_BIT) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // Next data bit is presented from the shifted value, LSB first.
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_nxt;
                  tx_d    = shift_nxt[0];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign busy     = ~tx_ready;
   assign tx       = tx_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations checked against a frame-level
// waveform model and a mid-bit sampling receiver model.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  d0;
   logic [4:0]  d1;
   logic [15:0] d2;
   logic [2:0]  valid, ready, txw, busy, done;

   int checks   = 0;
   int failures = 0;

   logic        samp[$];
   logic [15:0] words[$];

   typedef struct {
      int          s;
      logic [15:0] w;
      int          len;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) u0 (
      .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(valid[0]),
      .tx_ready(ready[0]), .tx(txw[0]), .busy(busy[0]), .done(done[0]));
   uart_tx #(.DATA_BITS(5), .CLKS_PER_BIT(2)) u1 (
      .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(valid[1]),
      .tx_ready(ready[1]), .tx(txw[1]), .busy(busy[1]), .done(done[1]));
   uart_tx #(.DATA_BITS(16), .CLKS_PER_BIT(3)) u2 (
      .clk(clk), .reset(reset), .tx_data(d2), .tx_valid(valid[2]),
      .tx_ready(ready[2]), .tx(txw[2]), .busy(busy[2]), .done(done[2]));

   function automatic int dbits(input int s);
      case (s)
         0:       return 8;
         1:       return 5;
         default: return 16;
      endcase
   endfunction

   function automatic int cpb(input int s);
      case (s)
         0:       return 4;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [15:0] mask(input int s, input logic [15:0] w);
      logic [15:0] r;
      r = w;
      for (int i = dbits(s); i < 16; i++) r[i] = 1'b0;
      return r;
   endfunction

   // Line level k cycles after the handshake: frame bit k/C of {stop, data, start}.
   function automatic logic model_bit(input int s, input logic [15:0] w, input int k);
      int idx;
      idx = k / cpb(s);
      if (idx == 0) return 1'b0;
      if (idx <= dbits(s)) return w[idx-1];
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input int s, input logic v, input logic [15:0] w);
      valid[s] = v;
      case (s)
         0:       d0 = w[7:0];
         1:       d1 = w[4:0];
         default: d2 = w;
      endcase
   endtask

   // Receiver model: find falling edges, sample each bit at its midpoint.
   task automatic decode(input int s);
      int          i;
      int          dn;
      int          c;
      logic [15:0] w;
      dn = dbits(s);
      c  = cpb(s);
      i  = 0;
      words.delete();
      while (i < samp.size()) begin
         if (samp[i] == 1'b0 && (i == 0 || samp[i-1] == 1'b1)) begin
            if (i + (dn + 1) * c + c / 2 >= samp.size()) break;
            w = '0;
            for (int b = 0; b < dn; b++) w[b] = samp[i + (b + 1) * c + c / 2];
            words.push_back(w);
            i += (dn + 1) * c + c / 2 + 1;
         end else begin
            i++;
         end
      end
   endtask

   task automatic send_frame(input int s, input logic [15:0] w, input int exp_len);
      int len;
      int wave_bad;
      len      = 0;
      wave_bad = 0;
      @(negedge clk);
      chk($sformatf("ready_pre s%0d", s), ready[s], 1);
      set_in(s, 1'b1, w);
      @(posedge clk);
      #1 set_in(s, 1'b0, 16'($urandom));
      samp.delete();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy[s]) break;
         samp.push_back(txw[s]);
         if (txw[s] !== model_bit(s, w, len)) wave_bad++;
         len++;
      end
      chk($sformatf("frame_len s%0d w%0h", s, w), len, exp_len);
      chk($sformatf("wave s%0d w%0h", s, w), wave_bad, 0);
      chk($sformatf("done_pulse s%0d", s), done[s], 1);
      chk($sformatf("ready_post s%0d", s), ready[s], 1);
      samp.push_back(txw[s]);
      @(negedge clk);
      chk($sformatf("done_once s%0d", s), done[s], 0);
      decode(s);
      chk($sformatf("rx_count s%0d", s), words.size(), 1);
      if (words.size() >= 1) chk($sformatf("rx_word s%0d", s), words[0], mask(s, w));
   endtask

   initial begin
      int rdy40;
      int rdy_mid;
      int rdy_early;
      int done_at;
      int done_cnt;
      int second_start;
      int bad;
      int s;

      vecs[0] = '{0, 16'h00A5, 40};
      vecs[1] = '{1, 16'h0015, 14};
      vecs[2] = '{2, 16'hBEEF, 54};
      vecs[3] = '{0, 16'h0000, 40};
      vecs[4] = '{0, 16'h00FF, 40};
      vecs[5] = '{1, 16'h001F, 14};
      vecs[6] = '{2, 16'h0001, 54};

      reset = 1'b1;
      valid = '0;
      d0 = '0;
      d1 = '0;
      d2 = '0;
      #1;
      chk("rst_tx", txw, 3'b111);
      chk("rst_busy", busy, 3'b000);
      chk("rst_done", done, 3'b000);
      chk("rst_ready", ready, 3'b111);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) send_frame(vecs[i].s, vecs[i].w, vecs[i].len);

      // Back-to-back: valid held high across the done cycle.
      @(negedge clk);
      set_in(0, 1'b1, 16'h0000);
      @(posedge clk);
      #1 d0 = 8'hFF;
      samp.delete();
      done_at = -1;
      done_cnt = 0;
      second_start = -1;
      rdy40 = 0;
      for (int i = 0; i < 96; i++) begin
         @(negedge clk);
         samp.push_back(txw[0]);
         if (done[0]) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (i == 40) rdy40 = ready[0];
         if (i == 41) valid[0] = 1'b0;
         if (second_start < 0 && i > 0 && txw[0] == 1'b0 && samp[i-1] == 1'b1) second_start = i;
      end
      chk("b2b_done_at", done_at, 40);
      chk("b2b_ready_done", rdy40, 1);
      chk("b2b_second_start", second_start, 41);
      chk("b2b_done_cnt", done_cnt, 2);
      decode(0);
      chk("b2b_rx_count", words.size(), 2);
      if (words.size() == 2) begin
         chk("b2b_rx0", words[0], 16'h0000);
         chk("b2b_rx1", words[1], 16'h00FF);
      end

      // Valid pulsed while busy must be ignored; data change has no effect.
      @(negedge clk);
      set_in(0, 1'b1, 16'h00C3);
      @(posedge clk);
      #1 d0 = 8'h5E;
      valid[0] = 1'b0;
      samp.delete();
      rdy_mid = -1;
      rdy_early = 0;
      done_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         samp.push_back(txw[0]);
         if (i < 40 && ready[0]) rdy_early++;
         if (done[0]) done_cnt++;
         if (i == 15) begin
            rdy_mid = ready[0];
            set_in(0, 1'b1, 16'h003C);
         end
         if (i == 16) set_in(0, 1'b0, 16'h0099);
      end
      chk("ign_ready_mid", rdy_mid, 0);
      chk("ign_ready_early", rdy_early, 0);
      chk("ign_done_cnt", done_cnt, 1);
      decode(0);
      chk("ign_rx_count", words.size(), 1);
      if (words.size() >= 1) chk("ign_rx_word", words[0], 16'h00C3);

      // Reset during data bit 3 of 0x55.
      @(negedge clk);
      set_in(0, 1'b1, 16'h0055);
      @(posedge clk);
      #1 set_in(0, 1'b0, 16'h0000);
      for (int i = 0; i < 17; i++) @(negedge clk);
      chk("mid_busy_before", busy[0], 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_tx", txw, 3'b111);
      chk("mid_rst_busy", busy, 3'b000);
      chk("mid_rst_done", done, 3'b000);
      chk("mid_rst_ready", ready, 3'b111);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         valid = 3'($urandom);
         d0 = 8'($urandom);
         d1 = 5'($urandom);
         d2 = 16'($urandom);
         @(negedge clk);
         #1;
         if (txw !== 3'b111 || busy !== 3'b000 || done !== 3'b000 || ready !== 3'b111) bad++;
      end
      chk("mid_rst_hold", bad, 0);
      valid = '0;
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done != 3'b000 || ready != 3'b111) done_cnt++;
      end
      chk("mid_no_done", done_cnt, 0);
      send_frame(0, 16'h0081, 40);

      // Randomised frames on random instances.
      for (int r = 0; r < 6; r++) begin
         s = int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_frame(s, 16'($urandom), (dbits(s) + 2) * cpb(s));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
